// File: rtl/sd_sector_buffer_pkg.sv
// ----------------------------------------------------------------------------
// sd_pkg
// Shared definitions for the SD sector buffer:
//   - controller control-register codes (CTRL_*)
//   - controller status code meaning "read complete" (STAT_READ_DONE)
//   - error-code and FSM state enumerations
// ----------------------------------------------------------------------------
package sd_pkg;

    localparam logic [7:0] CTRL_NOP   = 8'd0;
    localparam logic [7:0] CTRL_READ  = 8'd1;
    localparam logic [7:0] CTRL_WRITE = 8'd2;

    localparam logic [7:0] STAT_READ_DONE = 8'h01;

    typedef enum logic [1:0] {
        ERR_NONE    = 2'd0,
        ERR_STATUS  = 2'd1,
        ERR_SHORT   = 2'd2,
        ERR_TIMEOUT = 2'd3
    } err_code_e;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ISSUE     = 3'd1,
        ST_WAIT_DATA = 3'd2,
        ST_DONE      = 3'd3,
        ST_ERR       = 3'd4
    } state_e;

endpackage

// File: rtl/sd_sector_buffer_ram.sv
// ----------------------------------------------------------------------------
// sd_sector_ram
// Simple dual-port sector RAM, SECTOR_BYTES x 8.
//   clk      : clock
//   rst      : synchronous active-high reset (read register and valid only;
//              the array contents are never cleared)
//   wr_en    : write enable
//   wr_addr  : write address
//   wr_data  : write data
//   rd_en    : read enable
//   rd_addr  : read address
//   rd_data  : registered read data, one cycle after rd_en
//   rd_valid : high one cycle after rd_en
// A read and a write to the same address in the same cycle return the
// previous contents.
// ----------------------------------------------------------------------------
module sd_sector_ram #(
    parameter int SECTOR_BYTES = 512,
    parameter int ADDR_W       = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic              rd_en,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [7:0]        rd_data,
    output logic              rd_valid
);

    logic [7:0] mem [SECTOR_BYTES];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_addr] <= wr_data;
        end
    end

    // Read register stage: separate process so a same-address write in the
    // same cycle is not forwarded.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_data  <= 8'h00;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) begin
                rd_data <= mem[rd_addr];
            end
        end
    end

endmodule

// File: rtl/sd_sector_buffer.sv
// ----------------------------------------------------------------------------
// sd_sector_buffer
// Issues a single-sector read to the SD controller, captures the controller's
// byte write strobes into a sector RAM, checks byte count and completion
// status, and serves the finished sector through a synchronous read port.
//
// Optional feature: define SD_SECTOR_BUF_TIMEOUT_EN to enable an idle-cycle
// watchdog (TIMEOUT_CYCLES) in ISSUE/WAIT_DATA that ends in ERR code 3.
//
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_req_rd            host pulse starting a sector read
//   i_sector_addr       sector address, captured on request acceptance
//   o_busy              request accepted and not yet DONE/ERR
//   o_done, o_err       completion levels
//   o_err_code          0 none, 1 status, 2 short count, 3 timeout
//   o_controlreg        to controller: CTRL_READ while issuing, else CTRL_NOP
//   o_sd_addr           captured sector address to controller
//   i_data, i_addr      byte and byte index from controller
//   i_wr_nrd            controller write strobe (rising edge = one byte)
//   i_statusreg         controller status, STAT_READ_DONE on success
//   i_write_statusreg   status-valid strobe
//   i_rd_en, i_rd_addr  host RAM read request
//   o_rd_data           RAM read data, valid when o_rd_valid
//   o_rd_valid          high one cycle after i_rd_en
// ----------------------------------------------------------------------------
module sd_sector_buffer
    import sd_pkg::*;
#(
    parameter int SECTOR_BYTES   = 512,
    parameter int ADDR_W         = 9,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_req_rd,
    input  logic [31:0]       i_sector_addr,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_err,
    output logic [1:0]        o_err_code,
    output logic [7:0]        o_controlreg,
    output logic [31:0]       o_sd_addr,
    input  logic [7:0]        i_data,
    input  logic [31:0]       i_addr,
    input  logic              i_wr_nrd,
    input  logic [7:0]        i_statusreg,
    input  logic              i_write_statusreg,
    input  logic              i_rd_en,
    input  logic [ADDR_W-1:0] i_rd_addr,
    output logic [7:0]        o_rd_data,
    output logic              o_rd_valid
);

    localparam int CNT_W = ADDR_W + 1;
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SECTOR_BYTES);

    // Byte counter increment that sticks at a full sector.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v,
                                                 input logic            inc);
        if (inc && (v != CNT_FULL)) begin
            return v + CNT_W'(1);
        end
        return v;
    endfunction

    state_e           state, state_nx;
    err_code_e        err_code, err_code_nx;
    logic [CNT_W-1:0] byte_cnt;
    logic [CNT_W-1:0] cnt_eff;
    logic [31:0]      sd_addr;
    logic [7:0]       ctrl;
    logic             accept;
    logic             wr_prev;
    logic             wr_edge;
    logic             wr_keep;
    logic             busy;
    logic             tmo_hit;

    // Strobe detect: one byte per rising edge of i_wr_nrd, however long the
    // controller holds it high. Out-of-range indices (e.g. the trailing
    // index 512) are dropped.
    assign wr_edge = i_wr_nrd & ~wr_prev;
    assign wr_keep = wr_edge & (i_addr < 32'(SECTOR_BYTES));
    assign busy    = (state == ST_ISSUE) || (state == ST_WAIT_DATA);

    // Count including this cycle's byte, so a status strobe that coincides
    // with the last write edge sees the full sector.
    assign cnt_eff = sat_inc(byte_cnt, wr_keep & busy);

`ifdef SD_SECTOR_BUF_TIMEOUT_EN
    logic [31:0] tmo_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tmo_cnt <= 32'd0;
        end else if (!busy || wr_edge) begin
            tmo_cnt <= 32'd0;
        end else begin
            tmo_cnt <= tmo_cnt + 32'd1;
        end
    end

    assign tmo_hit = busy && !wr_edge && (tmo_cnt == 32'(TIMEOUT_CYCLES - 1));
`else
    // Watchdog compiled out: this expression is constant false.
    assign tmo_hit = (TIMEOUT_CYCLES < 0);
`endif

    // ---- state register / captured request ----
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state    <= ST_IDLE;
            err_code <= ERR_NONE;
            byte_cnt <= '0;
            sd_addr  <= 32'd0;
            wr_prev  <= 1'b0;
        end else begin
            state    <= state_nx;
            err_code <= err_code_nx;
            wr_prev  <= i_wr_nrd;
            byte_cnt <= accept ? '0 : cnt_eff;
            if (accept) begin
                sd_addr <= i_sector_addr;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        err_code_nx = err_code;
        ctrl        = CTRL_NOP;
        accept      = 1'b0;
        case (state)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (i_req_rd) begin
                    accept      = 1'b1;
                    err_code_nx = ERR_NONE;
                    state_nx    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                // Hold the read command only until the controller shows
                // activity, so it does not re-trigger when it returns idle.
                ctrl = CTRL_READ;
                if (wr_edge || i_write_statusreg) begin
                    state_nx = ST_WAIT_DATA;
                end else if (tmo_hit) begin
                    state_nx    = ST_ERR;
                    err_code_nx = ERR_TIMEOUT;
                end
            end
            ST_WAIT_DATA: begin
                if (i_write_statusreg) begin
                    if (i_statusreg != STAT_READ_DONE) begin
                        state_nx    = ST_ERR;
                        err_code_nx = ERR_STATUS;
                    end else if (cnt_eff != CNT_FULL) begin
                        state_nx    = ST_ERR;
                        err_code_nx = ERR_SHORT;
                    end else begin
                        state_nx = ST_DONE;
                    end
                end else if (tmo_hit) begin
                    state_nx    = ST_ERR;
                    err_code_nx = ERR_TIMEOUT;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    assign o_busy       = busy;
    assign o_done       = (state == ST_DONE);
    assign o_err        = (state == ST_ERR);
    assign o_err_code   = err_code;
    assign o_controlreg = ctrl;
    assign o_sd_addr    = sd_addr;

    // ---- sector storage ----
    sd_sector_ram #(
        .SECTOR_BYTES (SECTOR_BYTES),
        .ADDR_W       (ADDR_W)
    ) u_ram (
        .clk      (i_clk),
        .rst      (i_rst),
        .wr_en    (wr_keep),
        .wr_addr  (i_addr[ADDR_W-1:0]),
        .wr_data  (i_data),
        .rd_en    (i_rd_en),
        .rd_addr  (i_rd_addr),
        .rd_data  (o_rd_data),
        .rd_valid (o_rd_valid)
    );

endmodule

// File: tb/tb_sd_sector_buffer.sv
// ----------------------------------------------------------------------------
// tb_sd_sector_buffer
// Drives the sector buffer the way the SD controller would and checks its
// outputs and RAM contents against a reference model of the sector.
// ----------------------------------------------------------------------------
module tb_sd_sector_buffer;

    localparam int SB = 512;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_rd;
    logic [31:0] sector_addr;
    logic        busy, done, err;
    logic [1:0]  err_code;
    logic [7:0]  controlreg;
    logic [31:0] sd_addr;
    logic [7:0]  data;
    logic [31:0] addr;
    logic        wr_nrd;
    logic [7:0]  statusreg;
    logic        write_statusreg;
    logic        rd_en;
    logic [8:0]  rd_addr;
    logic [7:0]  rd_data;
    logic        rd_valid;

    always #5 clk = ~clk;

    sd_sector_buffer #(
        .SECTOR_BYTES   (SB),
        .ADDR_W         (9),
        .TIMEOUT_CYCLES (50)
    ) dut (
        .i_clk             (clk),
        .i_rst             (rst),
        .i_req_rd          (req_rd),
        .i_sector_addr     (sector_addr),
        .o_busy            (busy),
        .o_done            (done),
        .o_err             (err),
        .o_err_code        (err_code),
        .o_controlreg      (controlreg),
        .o_sd_addr         (sd_addr),
        .i_data            (data),
        .i_addr            (addr),
        .i_wr_nrd          (wr_nrd),
        .i_statusreg       (statusreg),
        .i_write_statusreg (write_statusreg),
        .i_rd_en           (rd_en),
        .i_rd_addr         (rd_addr),
        .o_rd_data         (rd_data),
        .o_rd_valid        (rd_valid)
    );

    int n_cmp = 0;
    int n_mis = 0;

    // Reference sector image: what the RAM must hold, and which bytes have
    // ever been written (the RAM is never cleared).
    logic [7:0]  ref_mem [SB];
    bit          ref_vld [SB];
    logic [31:0] q_addr [$];
    logic [7:0]  q_data [$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_check(input int a, input string tag);
        rd_en   = 1'b1;
        rd_addr = 9'(a);
        step();
        rd_en = 1'b0;
        chk({tag, "_rd_valid"}, rd_valid, 1);
        if (ref_vld[a]) chk({tag, "_rd_data"}, rd_data, ref_mem[a]);
        step();
        chk({tag, "_rd_valid_drop"}, rd_valid, 0);
    endtask

    task automatic req(input logic [31:0] sect, input string tag);
        sector_addr = sect;
        req_rd      = 1'b1;
        step();
        req_rd      = 1'b0;
        sector_addr = $urandom;
        chk({tag, "_req_busy"}, busy, 1);
        chk({tag, "_req_ctrl"}, controlreg, 1);
        chk({tag, "_req_sdaddr"}, sd_addr, sect);
        chk({tag, "_req_done"}, done, 0);
        chk({tag, "_req_err"}, err, 0);
        chk({tag, "_req_code"}, err_code, 0);
    endtask

    // One full read: request, the queued strobes, then the status strobe
    // (optionally in the same cycle as the last strobe).
    task automatic run_txn(input logic [31:0] sect, input int hold, input logic [7:0] status,
                           input bit merge_last, input string tag);
        int         acc;
        int         lead;
        int         cnt;
        logic [1:0] exp_code;
        bit         exp_done;
        logic [7:0] old_d;
        bit         old_v;
        acc = 0;
        req(sect, tag);
        lead = $urandom_range(0, 3);
        for (int w = 0; w < lead; w++) step();
        chk({tag, "_ctrl_before_first"}, controlreg, 1);
        for (int i = 0; i < q_addr.size(); i++) begin
            logic [31:0] a;
            a      = q_addr[i];
            addr   = a;
            data   = q_data[i];
            wr_nrd = 1'b1;
            old_v  = 1'b0;
            old_d  = 8'h00;
            if (merge_last && i == q_addr.size() - 1) begin
                statusreg       = status;
                write_statusreg = 1'b1;
            end
            if (a < SB) begin
                old_v = ref_vld[a[8:0]];
                old_d = ref_mem[a[8:0]];
                ref_mem[a[8:0]] = q_data[i];
                ref_vld[a[8:0]] = 1'b1;
                acc++;
            end
            if (i == 20 && a < SB) begin
                rd_en   = 1'b1;
                rd_addr = a[8:0];
            end
            for (int h = 0; h < hold; h++) begin
                step();
                write_statusreg = 1'b0;
                if (h == 0 && rd_en) begin
                    rd_en = 1'b0;
                    chk({tag, "_collide_valid"}, rd_valid, 1);
                    if (old_v) chk({tag, "_collide_old"}, rd_data, old_d);
                end
            end
            if (i == 0) chk({tag, "_ctrl_after_first"}, controlreg, 0);
            wr_nrd = 1'b0;
            if (i == 10) req_rd = 1'b1;
            step();
            req_rd = 1'b0;
        end
        if (!merge_last) begin
            statusreg       = status;
            write_statusreg = 1'b1;
            step();
            write_statusreg = 1'b0;
        end
        cnt      = (acc > SB) ? SB : acc;
        exp_done = 1'b0;
        if (status != 8'h01)  exp_code = 2'd1;
        else if (cnt != SB)   exp_code = 2'd2;
        else begin exp_code = 2'd0; exp_done = 1'b1; end
        chk({tag, "_done"}, done, exp_done);
        chk({tag, "_err"}, err, !exp_done);
        chk({tag, "_code"}, err_code, exp_code);
        chk({tag, "_busy_end"}, busy, 0);
        chk({tag, "_sdaddr_held"}, sd_addr, sect);
        for (int k = 0; k < 6; k++) rd_check($urandom_range(0, SB - 1), tag);
    endtask

    task automatic fill_seq(input int n, input bit rnd_data);
        q_addr.delete();
        q_data.delete();
        for (int i = 0; i < n; i++) begin
            q_addr.push_back(32'(i));
            q_data.push_back(rnd_data ? 8'($urandom) : 8'(i));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "bench timed out");
    end

    initial begin
        logic [7:0] st;
        rst = 1'b1; req_rd = 1'b0; sector_addr = 32'd0;
        data = 8'd0; addr = 32'd0; wr_nrd = 1'b0;
        statusreg = 8'd0; write_statusreg = 1'b0;
        rd_en = 1'b0; rd_addr = 9'd0;
        for (int i = 0; i < SB; i++) ref_vld[i] = 1'b0;
        step(); step();
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_code", err_code, 0);
        chk("rst_ctrl", controlreg, 0);
        chk("rst_sdaddr", sd_addr, 0);
        chk("rst_rdvalid", rd_valid, 0);
        chk("rst_rddata", rd_data, 0);
        rst = 1'b0;
        step();

        // Full sector plus trailing index 512, data = index.
        fill_seq(SB + 1, 1'b0);
        run_txn(32'h10, 1, 8'h01, 1'b0, "full");
        rd_check(5, "full5");
        chk("full_ram5_const", rd_data, 8'h05);
        rd_check(511, "full511");
        chk("full_ram511_const", rd_data, 8'hFF);

        // Bad status after a full sector.
        fill_seq(SB, 1'b1);
        run_txn(32'h2000, 1, 8'h03, 1'b0, "badstat");

        // Short sector.
        fill_seq(300, 1'b1);
        run_txn($urandom, 1, 8'h01, 1'b0, "short");

        // Strobe held high for three cycles per byte.
        fill_seq(SB, 1'b1);
        run_txn($urandom, 3, 8'h01, 1'b0, "hold3");

        // Status strobe in the same cycle as the last write edge.
        fill_seq(SB, 1'b1);
        run_txn($urandom, 1, 8'h01, 1'b1, "merge");

        // Reset part-way through a fill.
        req(32'h55, "rstmid");
        for (int i = 0; i < 100; i++) begin
            addr   = 32'(i);
            data   = 8'($urandom);
            wr_nrd = 1'b1;
            ref_mem[i] = data;
            ref_vld[i] = 1'b1;
            step();
            wr_nrd = 1'b0;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("rstmid_busy", busy, 0);
        chk("rstmid_ctrl", controlreg, 0);
        chk("rstmid_sdaddr", sd_addr, 0);
        rd_check(50, "rstmid");
        fill_seq(SB, 1'b1);
        run_txn($urandom, 1, 8'h01, 1'b0, "after_rst");

        // Random strobe mixes: random indices (some out of range, some
        // repeated), random data and random status.
        for (int t = 0; t < 4; t++) begin
            int n;
            n = $urandom_range(480, 560);
            q_addr.delete();
            q_data.delete();
            for (int i = 0; i < n; i++) begin
                q_addr.push_back(($urandom_range(0, 9) == 0) ? 32'($urandom_range(SB, 700))
                                                             : 32'(i % SB));
                q_data.push_back(8'($urandom));
            end
            st = ($urandom_range(0, 2) != 0) ? 8'h01 : 8'($urandom_range(2, 255));
            run_txn($urandom, $urandom_range(1, 2), st, 1'($urandom_range(0, 1)), "rand");
        end

`ifdef SD_SECTOR_BUF_TIMEOUT_EN
        // No strobes at all: watchdog fires in cycle 51 after ISSUE entry.
        req(32'h77, "tmo");
        for (int c = 0; c < 49; c++) step();
        chk("tmo_busy_c50", busy, 1);
        step();
        chk("tmo_err", err, 1);
        chk("tmo_code", err_code, 3);
        chk("tmo_ctrl", controlreg, 0);
        chk("tmo_busy", busy, 0);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
